prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed, checksummed byte stream, writes it into
// program memory and holds the CPU core in reset until a complete frame verifies.
module prog_loader #(
   parameter logic [7:0] SYNC_BYTE = 8'h5A,
   parameter int         TIMEOUT   = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       load_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       cpu_reset,
   output logic       loaded,
   output logic       error
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, RUN} state_t;

   state_t            state, state_n;
   logic [7:0]        len_q, len_n;
   logic [7:0]        cnt_q, cnt_n;
   logic [7:0]        acc_q, acc_n;
   logic [IDLE_W-1:0] idle_q, idle_n;
   logic              err_n;
   logic              we_n;
   logic [7:0]        addr_n, wdata_n;
   logic              xfer;
   logic              run_hold;

   assign xfer     = in_valid & in_ready;
   assign run_hold = (state == RUN) && (state_n == RUN);

   always_comb begin
      state_n = state;
      len_n   = len_q;
      cnt_n   = cnt_q;
      acc_n   = acc_q;
      idle_n  = idle_q;
      err_n   = error;
      we_n    = 1'b0;
      addr_n  = mem_addr;
      wdata_n = mem_wdata;
      case (state)
         IDLE: begin
            idle_n = '0;
            if (xfer && (in_data == SYNC_BYTE)) begin
               state_n = LEN;
               err_n   = 1'b0;
            end
         end
         LEN, DATA, CHK: begin
            if (xfer) begin
               idle_n = '0;
               case (state)
                  LEN: begin
                     len_n   = in_data;
                     cnt_n   = 8'h00;
                     acc_n   = 8'h00;
                     state_n = DATA;
                  end
                  DATA: begin
                     we_n    = 1'b1;
                     addr_n  = cnt_q;
                     wdata_n = in_data;
                     acc_n   = acc_q + in_data;
                     cnt_n   = cnt_q + 8'd1;
                     // len_q - 1 wraps to 0xFF when LEN = 0, giving the 256-byte frame
                     if (cnt_q == (len_q - 8'd1))
                        state_n = CHK;
                  end
                  default: begin
                     if (in_data == acc_q) begin
                        state_n = RUN;
                     end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                     end
                  end
               endcase
            end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
               err_n   = 1'b1;
               idle_n  = '0;
               state_n = IDLE;
            end else begin
               idle_n = idle_q + 1'b1;
            end
         end
         RUN: begin
            if (load_req)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         len_q     <= 8'h00;
         cnt_q     <= 8'h00;
         acc_q     <= 8'h00;
         idle_q    <= '0;
         error     <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 8'h00;
         mem_wdata <= 8'h00;
         in_ready  <= 1'b0;
         cpu_reset <= 1'b1;
         loaded    <= 1'b0;
      end else begin
         state     <= state_n;
         len_q     <= len_n;
         cnt_q     <= cnt_n;
         acc_q     <= acc_n;
         idle_q    <= idle_n;
         error     <= err_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         in_ready  <= (state_n != RUN);
         // CPU is released one edge after RUN is entered and caught again on the exit edge
         cpu_reset <= ~run_hold;
         loaded    <= run_hold;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus hand-written
// sequences for the 256-byte frame, idle timeout and mid-frame reset.
module tb_prog_loader;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       load_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_reset;
   logic       loaded;
   logic       error;

   int n_checks = 0;
   int n_pass   = 0;
   int we_cnt   = 0;

   prog_loader #(.SYNC_BYTE(8'h5A), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .load_req  (load_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_reset (cpu_reset),
      .loaded    (loaded),
      .error     (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (mem_we === 1'b1) we_cnt++;
   end

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        lr;
      logic [20:0] exp;
   } vec_t;

   localparam logic [20:0] RST_OUTS = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};

   function automatic vec_t mk(logic v, logic [7:0] d, logic lr, logic r, logic w,
                               logic [7:0] a, logic [7:0] wd, logic c, logic l, logic e);
      vec_t t;
      t.v   = v;
      t.d   = d;
      t.lr  = lr;
      t.exp = {r, w, a, wd, c, l, e};
      return t;
   endfunction

   function automatic logic [20:0] outs();
      return {in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, loaded, error};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      step();
      in_valid = 1'b0;
   endtask

   vec_t tbl [21];
   int   bad;
   int   base;

   initial begin
      tbl[0]  = mk(1, 8'h5A, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
      tbl[1]  = mk(1, 8'h03, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
      tbl[2]  = mk(1, 8'h11, 0, 1, 1, 8'h00, 8'h11, 1, 0, 0);
      tbl[3]  = mk(1, 8'h22, 0, 1, 1, 8'h01, 8'h22, 1, 0, 0);
      tbl[4]  = mk(1, 8'h33, 0, 1, 1, 8'h02, 8'h33, 1, 0, 0);
      tbl[5]  = mk(1, 8'h66, 0, 0, 0, 8'h02, 8'h33, 1, 0, 0);
      tbl[6]  = mk(0, 8'h00, 0, 0, 0, 8'h02, 8'h33, 0, 1, 0);
      tbl[7]  = mk(1, 8'h77, 0, 0, 0, 8'h02, 8'h33, 0, 1, 0);
      tbl[8]  = mk(0, 8'h00, 1, 1, 0, 8'h02, 8'h33, 1, 0, 0);
      tbl[9]  = mk(1, 8'h5A, 0, 1, 0, 8'h02, 8'h33, 1, 0, 0);
      tbl[10] = mk(1, 8'h02, 0, 1, 0, 8'h02, 8'h33, 1, 0, 0);
      tbl[11] = mk(1, 8'h01, 0, 1, 1, 8'h00, 8'h01, 1, 0, 0);
      tbl[12] = mk(1, 8'h02, 0, 1, 1, 8'h01, 8'h02, 1, 0, 0);
      tbl[13] = mk(1, 8'h04, 0, 1, 0, 8'h01, 8'h02, 1, 0, 1);
      tbl[14] = mk(1, 8'h13, 0, 1, 0, 8'h01, 8'h02, 1, 0, 1);
      tbl[15] = mk(1, 8'h5A, 0, 1, 0, 8'h01, 8'h02, 1, 0, 0);
      tbl[16] = mk(0, 8'h00, 0, 1, 0, 8'h01, 8'h02, 1, 0, 0);
      tbl[17] = mk(1, 8'h01, 0, 1, 0, 8'h01, 8'h02, 1, 0, 0);
      tbl[18] = mk(1, 8'h5A, 0, 1, 1, 8'h00, 8'h5A, 1, 0, 0);
      tbl[19] = mk(1, 8'h5A, 0, 0, 0, 8'h00, 8'h5A, 1, 0, 0);
      tbl[20] = mk(0, 8'h00, 0, 0, 0, 8'h00, 8'h5A, 0, 1, 0);

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      load_req = 1'b0;
      #1 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", {11'b0, outs()}, {11'b0, RST_OUTS});
      reset = 1'b1;
      step();
      check("ready_after_reset", {11'b0, outs()},
            {11'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});

      for (int i = 0; i < 21; i++) begin
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         load_req = tbl[i].lr;
         step();
         check($sformatf("vec%0d", i), {11'b0, outs()}, {11'b0, tbl[i].exp});
      end
      in_valid = 1'b0;
      load_req = 1'b0;

      // 256-byte frame (LEN = 0), checksum 256 * 0x01 mod 256 = 0x00
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      base = we_cnt;
      send(8'h5A);
      send(8'h00);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         send(8'h01);
         if (!(mem_we === 1'b1 && mem_addr === i[7:0] && mem_wdata === 8'h01)) bad++;
      end
      check("burst256_write_seq_errors", bad, 0);
      send(8'h00);
      step();
      check("burst256_write_count", we_cnt - base, 256);
      check("burst256_run", {29'b0, loaded, cpu_reset, error}, {29'b0, 1'b1, 1'b0, 1'b0});

      // idle timeout inside DATA
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      base = we_cnt;
      send(8'h5A);
      send(8'h04);
      send(8'hAA);
      for (int i = 0; i < TO - 2; i++) step();
      check("timeout_not_early", {31'b0, error}, 32'd0);
      step();
      step();
      check("timeout_error", {11'b0, outs()},
            {11'b0, 1'b1, 1'b0, 8'h00, 8'hAA, 1'b1, 1'b0, 1'b1});
      check("timeout_write_count", we_cnt - base, 1);
      send(8'h5A);
      check("timeout_back_in_idle", {31'b0, error}, 32'd0);
      check("timeout_no_more_writes", we_cnt - base, 1);

      // reset during the second data byte of a 3-byte frame (already past SYNC)
      send(8'h03);
      send(8'h11);
      check("midframe_first_write", {23'b0, mem_we, mem_wdata}, {23'b0, 1'b1, 8'h11});
      in_valid = 1'b1;
      in_data  = 8'h22;
      #2 reset = 1'b0;
      #1;
      check("midframe_async_reset", {11'b0, outs()}, {11'b0, RST_OUTS});
      base = we_cnt;
      step();
      step();
      step();
      check("midframe_held_in_reset", {11'b0, outs()}, {11'b0, RST_OUTS});
      reset    = 1'b1;
      in_valid = 1'b0;
      step();
      check("midframe_ready_after", {11'b0, outs()},
            {11'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
      send(8'h22);
      send(8'h33);
      step();
      check("midframe_no_writes", we_cnt - base, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
